// File: rtl/color_decoder_pkg.sv
// Shared VGA pixel definitions: color width, default decode colors and RGB field slices.
// Also names the two pixel-path states used by the decoder.
package color_decoder_pkg;

    localparam int COLOR_W = 12;

    localparam logic [COLOR_W-1:0] COLOR_0_DEF = 12'h000;
    localparam logic [COLOR_W-1:0] COLOR_1_DEF = 12'hFFF;

    localparam int R_HI = 11;
    localparam int R_LO = 8;
    localparam int G_HI = 7;
    localparam int G_LO = 4;
    localparam int B_HI = 3;
    localparam int B_LO = 0;

    typedef enum logic {
        PIX_ACC  = 1'b0,
        PIX_EMIT = 1'b1
    } pix_state_e;

endpackage

// File: rtl/color_decoder_fifo.sv
// byte_fifo: synchronous 8-bit FIFO, power-of-two depth, accepts push+pop together when full.
// out of the head entry reads as 8'h00 whenever the FIFO is empty.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    // A pop frees the slot the push needs, so a full FIFO still takes the push.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    assign pop_data = empty ? 8'h00 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/color_decoder.sv
// Recovers 1-bit-per-pixel data from a 12-bit RGB stream and packs it MSB-first into bytes.
//
// state    | meaning
// PIX_ACC  | accumulating bits, bit_cnt 0..6 (or frame start / idle)
// PIX_EMIT | bit_cnt == 7 on a valid pixel, completed byte pushed this cycle
module color_decoder
    import color_decoder_pkg::*;
#(
    parameter logic [COLOR_W-1:0] COLOR_0    = COLOR_0_DEF,
    parameter logic [COLOR_W-1:0] COLOR_1    = COLOR_1_DEF,
    parameter int                 FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  red,
    input  logic [3:0]  green,
    input  logic [3:0]  blue,
    input  logic        pix_valid,
    input  logic        frame_start,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] err_count,
    output logic        overflow
);

    logic [COLOR_W-1:0] pix;
    logic               bit_in, unmatched;
    pix_state_e         state;

    logic [6:0]  sh_q, sh_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] err_count_q, err_count_d;
    logic        overflow_q, overflow_d;

    logic       push, pop, fifo_full, fifo_empty;
    logic [7:0] push_data;

    assign pix[R_HI:R_LO] = red;
    assign pix[G_HI:G_LO] = green;
    assign pix[B_HI:B_LO] = blue;

    // COLOR_1 is tested first so it wins if both colors are configured equal.
    assign bit_in    = (pix == COLOR_1);
    assign unmatched = !bit_in && (pix != COLOR_0);

    assign state = (pix_valid && !frame_start && bit_cnt_q == 3'd7) ? PIX_EMIT : PIX_ACC;

    assign push      = (state == PIX_EMIT);
    assign push_data = {sh_q, bit_in};
    assign pop       = out_valid && out_ready;

    always_comb begin
        sh_d        = sh_q;
        bit_cnt_d   = bit_cnt_q;
        err_count_d = err_count_q;
        overflow_d  = overflow_q;
        if (pix_valid) begin
            if (frame_start) begin
                sh_d        = {6'b0, bit_in};
                bit_cnt_d   = 3'd1;
                err_count_d = unmatched ? 16'd1 : 16'd0;
            end else begin
                sh_d      = {sh_q[5:0], bit_in};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (unmatched && err_count_q != 16'hFFFF)
                    err_count_d = err_count_q + 16'd1;
            end
        end
        if (push && fifo_full && !pop) overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_q        <= '0;
            bit_cnt_q   <= '0;
            err_count_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            sh_q        <= sh_d;
            bit_cnt_q   <= bit_cnt_d;
            err_count_q <= err_count_d;
            overflow_q  <= overflow_d;
        end
    end

    byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .pop_data (out_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign err_count = err_count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_color_decoder.sv
// Directed bench for color_decoder: a vector table for the streaming cases plus
// hand-written sequences for FIFO overflow, full push+pop and mid-byte reset.
module tb_color_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  red, green, blue;
    logic        pix_valid, frame_start, out_ready;
    logic [7:0]  out_data;
    logic        out_valid, overflow;
    logic [15:0] err_count;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    color_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .pix_valid  (pix_valid),
        .frame_start(frame_start),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err_count  (err_count),
        .overflow   (overflow)
    );

    typedef struct {
        logic        pv;
        logic        fs;
        logic [11:0] rgb;
        logic        ev;
        logic [7:0]  ed;
        logic [15:0] ee;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [11:0] px(input logic b);
        return b ? 12'hFFF : 12'h000;
    endfunction

    function automatic void add(input logic pv, input logic fs, input logic [11:0] rgb,
                                input logic ev, input logic [7:0] ed, input logic [15:0] ee);
        vec_t v;
        v.pv = pv; v.fs = fs; v.rgb = rgb; v.ev = ev; v.ed = ed; v.ee = ee;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic pv, input logic fs, input logic [11:0] rgb, input logic rdy);
        @(negedge clk);
        pix_valid   = pv;
        frame_start = fs;
        {red, green, blue} = rgb;
        out_ready   = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic feed_byte(input logic [7:0] b, input logic rdy);
        for (int j = 7; j >= 0; j--) step(1'b1, 1'b0, px(b[j]), rdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; pix_valid = 1'b0; frame_start = 1'b0; out_ready = 1'b0;
        {red, green, blue} = 12'h000;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_state", {out_valid, out_data, err_count, overflow}, {1'b0, 8'h00, 16'h0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b1;
        logic [7:0] exp_q[$];
        int n;

        rst_n = 1'b1; pix_valid = 1'b0; frame_start = 1'b0; out_ready = 1'b0;
        {red, green, blue} = 12'h000;

        // 1,0,1,1,0,0,1,0 -> 8'hB2
        b1 = 8'hB2;
        for (int j = 7; j >= 1; j--) add(1, 0, px(b1[j]), 0, 8'h00, 0);
        add(1, 0, px(b1[0]), 1, 8'hB2, 0);
        // partial byte of 5, then frame_start with 8 white pixels -> single 8'hFF
        for (int i = 0; i < 5; i++) add(1, 0, 12'hFFF, 0, 8'h00, 0);
        add(1, 1, 12'hFFF, 0, 8'h00, 0);
        for (int i = 0; i < 6; i++) add(1, 0, 12'hFFF, 0, 8'h00, 0);
        add(1, 0, 12'hFFF, 1, 8'hFF, 0);
        // two unmatched pixels then six black -> 8'h00, err 2
        add(1, 0, 12'h0F0, 0, 8'h00, 1);
        add(1, 0, 12'h123, 0, 8'h00, 2);
        for (int i = 0; i < 5; i++) add(1, 0, 12'h000, 0, 8'h00, 2);
        add(1, 0, 12'h000, 1, 8'h00, 2);
        // frame_start on white clears err; a frame_start without pix_valid is ignored
        add(1, 1, 12'hFFF, 0, 8'h00, 0);
        add(0, 1, 12'h123, 0, 8'h00, 0);
        for (int i = 0; i < 6; i++) add(1, 0, 12'h000, 0, 8'h00, 0);
        add(1, 0, 12'h000, 1, 8'h80, 0);
        add(0, 0, 12'h000, 0, 8'h00, 0);

        do_reset();

        foreach (vecs[i]) begin
            step(vecs[i].pv, vecs[i].fs, vecs[i].rgb, 1'b1);
            check($sformatf("vec%0d", i), {out_valid, out_data, err_count, overflow},
                  {vecs[i].ev, vecs[i].ed, vecs[i].ee, 1'b0});
        end

        // Overflow: six bytes with the consumer stalled, only the first four survive.
        do_reset();
        feed_byte(8'h11, 1'b0);
        feed_byte(8'h22, 1'b0);
        feed_byte(8'h33, 1'b0);
        feed_byte(8'h44, 1'b0);
        check("ovf_full_no_drop", {out_valid, out_data, overflow}, {1'b1, 8'h11, 1'b0});
        feed_byte(8'h55, 1'b0);
        check("ovf_set_5th", {2'b0, overflow}, 3'b1);
        feed_byte(8'h66, 1'b0);
        check("ovf_head_stable", {out_valid, out_data, overflow}, {1'b1, 8'h11, 1'b1});
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        n = 0;
        while (out_valid && n < 10) begin
            if (n < 4) check($sformatf("ovf_drain%0d", n), {24'h0, out_data}, {24'h0, exp_q[n]});
            step(1'b0, 1'b0, 12'h000, 1'b1);
            n++;
        end
        check("ovf_drain_count", n, 4);
        check("ovf_sticky", {31'h0, overflow}, 1);

        // Full FIFO, last pixel of the next byte lands on a pop: nothing dropped.
        do_reset();
        feed_byte(8'hA1, 1'b0);
        feed_byte(8'hA2, 1'b0);
        feed_byte(8'hA3, 1'b0);
        feed_byte(8'hA4, 1'b0);
        b1 = 8'hA5;
        for (int j = 7; j >= 1; j--) step(1'b1, 1'b0, px(b1[j]), 1'b0);
        step(1'b1, 1'b0, px(b1[0]), 1'b1);
        check("fullpop_no_ovf", {out_valid, out_data, overflow}, {1'b1, 8'hA2, 1'b0});
        exp_q = '{8'hA2, 8'hA3, 8'hA4, 8'hA5};
        n = 0;
        while (out_valid && n < 10) begin
            if (n < 4) check($sformatf("fullpop_drain%0d", n), {24'h0, out_data}, {24'h0, exp_q[n]});
            step(1'b0, 1'b0, 12'h000, 1'b1);
            n++;
        end
        check("fullpop_count", n, 4);

        // Reset mid-byte with a queued byte and a nonzero error count.
        do_reset();
        feed_byte(8'hFF, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 12'h123, 1'b0);
        check("midrst_before", {out_valid, out_data, err_count}, {1'b1, 8'hFF, 16'd3});
        @(negedge clk);
        rst_n = 1'b0; pix_valid = 1'b1; {red, green, blue} = 12'h123;
        @(posedge clk);
        #1;
        check("midrst_cleared", {out_valid, out_data, err_count, overflow}, {1'b0, 8'h00, 16'h0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1; pix_valid = 1'b0;
        b1 = 8'hA5;
        for (int j = 7; j >= 1; j--) step(1'b1, 1'b0, px(b1[j]), 1'b0);
        check("midrst_partial", {31'h0, out_valid}, 0);
        step(1'b1, 1'b0, px(b1[0]), 1'b0);
        check("midrst_fresh_byte", {out_valid, out_data, err_count}, {1'b1, 8'hA5, 16'h0});

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/color_decoder.md
# color_decoder

Capture-side counterpart of the 1-bit VGA color encoder. It samples the 12-bit RGB pixel stream, classifies each visible pixel as `COLOR_0` or `COLOR_1`, and packs the recovered bits MSB-first into bytes. Bytes are delivered through a 4-entry FIFO with a valid/ready handshake. It sits on the video bus beside the DAC and is used for frame loopback checking and debug readback of the framebuffer.

## Interface
- `COLOR_0`, default 12'h000: color decoded as bit 0. Layout {R[3:0],G[3:0],B[3:0]}.
- `COLOR_1`, default 12'hFFF: color decoded as bit 1.
- `FIFO_DEPTH`, default 4: output FIFO entries; power of two, minimum 2.
- `clk` input 1: sole clock. Reset is synchronous and active-low.
- `rst_n` input 1: synchronous active-low reset.
- `red` input 4: pixel red.
- `green` input 4: pixel green.
- `blue` input 4: pixel blue.
- `pix_valid` input 1: pixel present this cycle, in the visible region.
- `frame_start` input 1: first pixel of a frame; qualified by `pix_valid`.
- `out_data` output 8: packed byte, first pixel in bit 7.
- `out_valid` output 1: FIFO non-empty.
- `out_ready` input 1: consumer accepts `out_data` when high with `out_valid`.
- `err_count` output 16: unmatched pixels this frame; saturates at 16'hFFFF.
- `overflow` output 1: sticky; a completed byte was dropped because the FIFO was full.

## Operation
- Classification: `{red,green,blue}`==`COLOR_1` gives 1. ==`COLOR_0` gives 0. Any other value gives bit 0 and an error.
- If `COLOR_0`==`COLOR_1`, `COLOR_1` wins.
- Shift register `sh[6:0]` and 3-bit `bit_cnt`. Each `pix_valid` cycle shifts the bit in and increments `bit_cnt`.
- When `bit_cnt`==7, `{sh,bit}` is pushed to the FIFO and `bit_cnt` wraps to 0.
- `frame_start`&`pix_valid`: the partial byte is discarded and `bit_cnt` restarts, so this pixel becomes bit 7 of a new byte. `err_count` is loaded with 1 if this pixel is unmatched, otherwise 0. FIFO contents and `overflow` are untouched.
- `frame_start` without `pix_valid` is ignored.
- Push when full with no pop: the byte is dropped and `overflow` is set. `overflow` clears only on reset.
- Push and pop in the same cycle with the FIFO full: both happen, nothing is dropped, and occupancy is unchanged.
- Pop occurs on `out_valid`&`out_ready`. `out_data` holds the head entry and is stable while `out_valid`&!`out_ready`.
- Pixel path states: ACC (accumulating, `bit_cnt` 0..6) and EMIT (`bit_cnt`==7 and a push is due this cycle). It has no stall: input is never back-pressured.

## Timing
- Reset (`rst_n` low at a `clk` edge) clears `sh`, `bit_cnt`, FIFO pointers and count, `err_count`, and `overflow`.
- Output values in reset: `out_valid`=0, `err_count`=0, `overflow`=0, `out_data`=8'h00.
- Reset mid-byte or mid-frame discards everything. The first `pix_valid` after reset is bit 7.
- Latency: the 8th pixel is sampled at edge N. `out_valid` is high and `out_data` is valid after edge N (registered, one cycle from the last pixel) when the FIFO was empty.
- `err_count` updates at the same edge that samples the pixel.
- Throughput: one pixel per clock sustained. One byte per 8 clocks, so a consumer with `out_ready` tied high never overflows.
- FIFO pointers use log2(`FIFO_DEPTH`) bits with wrap-around. Occupancy uses log2(`FIFO_DEPTH`)+1 bits. Full means occupancy==`FIFO_DEPTH`.

## Structure
- A shared VGA package holds the 12-bit color width constant, the default `COLOR_0`/`COLOR_1` values, and the RGB field slice offsets (11:8, 7:4, 3:0). The encoder and decoder both use them.
- One sub-module, `byte_fifo`: synchronous, parameterized depth, 8-bit, with push/pop/full/empty, same-cycle push+pop on full, and `rst_n`.
- Classification, shift/pack, and counters stay in the top level.

## Test plan
- Reset then 8 pixels 1,0,1,1,0,0,1,0 (FFF/000), `out_ready`=1: `out_data`=8'hB2 one cycle after the 8th pixel, `err_count`=0.
- 5 pixels, then `frame_start` with 8 pixels of FFF: exactly one byte 8'hFF is emitted, the partial byte is discarded, and `err_count` is 0 after the frame start.
- Pixels 12'h0F0, 12'h123 and six of 12'h000: byte 8'h00 and `err_count`=2. A following `frame_start` on an FFF pixel sets `err_count`=0.
- `out_ready`=0 with 48 pixels: 4 bytes are queued, the 5th and 6th are dropped, and `overflow`=1. Releasing `out_ready` drains exactly 4 bytes in order.
- FIFO full, 8th pixel coincident with a pop: no drop, `overflow` stays 0, and occupancy stays 4.
- Assert `rst_n` low mid-byte with FIFO non-empty: next cycle `out_valid`=0 and `err_count`=0. The next 8 pixels form a fresh byte.
